// File: rtl/rvsteel_bus_arbiter.sv
// Two-manager, one-subordinate round-robin arbiter for the RISC-V Steel system bus.
// Define RVSTEEL_BUS_TIMEOUT_EN to fault transactions the subordinate never answers.
module rvsteel_bus_arbiter #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [ADDR_WIDTH-1:0]   m0_address,
  input  logic                    m0_read_request,
  input  logic                    m0_write_request,
  input  logic [DATA_WIDTH-1:0]   m0_write_data,
  input  logic [DATA_WIDTH/8-1:0] m0_write_strobe,
  output logic [DATA_WIDTH-1:0]   m0_read_data,
  output logic                    m0_response,
  output logic                    m0_fault,
  input  logic [ADDR_WIDTH-1:0]   m1_address,
  input  logic                    m1_read_request,
  input  logic                    m1_write_request,
  input  logic [DATA_WIDTH-1:0]   m1_write_data,
  input  logic [DATA_WIDTH/8-1:0] m1_write_strobe,
  output logic [DATA_WIDTH-1:0]   m1_read_data,
  output logic                    m1_response,
  output logic                    m1_fault,
  output logic [ADDR_WIDTH-1:0]   s_address,
  output logic                    s_read_request,
  output logic                    s_write_request,
  output logic [DATA_WIDTH-1:0]   s_write_data,
  output logic [DATA_WIDTH/8-1:0] s_write_strobe,
  input  logic [DATA_WIDTH-1:0]   s_read_data,
  input  logic                    s_response,
  output logic                    grant_owner,
  output logic                    busy
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] GRANT = 2'd1;
  localparam logic [1:0] RESP  = 2'd2;

  logic [1:0]              state;
  logic                    last_grant;
  logic                    req0;
  logic                    req1;
  logic                    pick;
  logic                    pick_rd;
  logic                    pick_wr;
  logic [ADDR_WIDTH-1:0]   pick_addr;
  logic [DATA_WIDTH-1:0]   pick_wdata;
  logic [DATA_WIDTH/8-1:0] pick_strb;
  logic                    timeout;

  assign req0 = m0_read_request | m0_write_request;
  assign req1 = m1_read_request | m1_write_request;

  // On a tie the manager that did not win last time is granted.
  always_comb begin
    pick = 1'b0;
    if (req0 && req1) pick = ~last_grant;
    else if (req1)    pick = 1'b1;
  end

  always_comb begin
    pick_rd    = m0_read_request;
    pick_wr    = m0_write_request;
    pick_addr  = m0_address;
    pick_wdata = m0_write_data;
    pick_strb  = m0_write_strobe;
    if (pick) begin
      pick_rd    = m1_read_request;
      pick_wr    = m1_write_request;
      pick_addr  = m1_address;
      pick_wdata = m1_write_data;
      pick_strb  = m1_write_strobe;
    end
  end

`ifdef RVSTEEL_BUS_TIMEOUT_EN
  localparam int CW = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  localparam logic [CW-1:0] TLAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] tcount;

  // Counter is 0 on the first GRANT cycle, so the timeout fires on GRANT cycle TIMEOUT_CYCLES.
  always_ff @(posedge clock) begin
    if (reset || state != GRANT) tcount <= '0;
    else                         tcount <= tcount + CW'(1);
  end

  assign timeout = (state == GRANT) && (tcount == TLAST);
`else
  localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state           <= IDLE;
      last_grant      <= 1'b1;
      grant_owner     <= 1'b0;
      busy            <= 1'b0;
      s_address       <= '0;
      s_read_request  <= 1'b0;
      s_write_request <= 1'b0;
      s_write_data    <= '0;
      s_write_strobe  <= '0;
      m0_read_data    <= '0;
      m0_response     <= 1'b0;
      m0_fault        <= 1'b0;
      m1_read_data    <= '0;
      m1_response     <= 1'b0;
      m1_fault        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req0 || req1) begin
            state           <= GRANT;
            busy            <= 1'b1;
            grant_owner     <= pick;
            last_grant      <= pick;
            s_address       <= pick_addr;
            s_write_data    <= pick_wdata;
            s_write_strobe  <= pick_strb;
            s_read_request  <= pick_rd;
            s_write_request <= pick_wr & ~pick_rd;
          end
        end
        GRANT: begin
          // s_response takes priority over a coincident timeout.
          if (s_response) begin
            state           <= RESP;
            s_read_request  <= 1'b0;
            s_write_request <= 1'b0;
            if (grant_owner) begin
              m1_response  <= 1'b1;
              m1_read_data <= s_read_request ? s_read_data : '0;
            end else begin
              m0_response  <= 1'b1;
              m0_read_data <= s_read_request ? s_read_data : '0;
            end
          end else if (timeout) begin
            state           <= RESP;
            s_read_request  <= 1'b0;
            s_write_request <= 1'b0;
            if (grant_owner) begin
              m1_response <= 1'b1;
              m1_fault    <= 1'b1;
            end else begin
              m0_response <= 1'b1;
              m0_fault    <= 1'b1;
            end
          end
        end
        RESP: begin
          state        <= IDLE;
          busy         <= 1'b0;
          m0_response  <= 1'b0;
          m0_fault     <= 1'b0;
          m0_read_data <= '0;
          m1_response  <= 1'b0;
          m1_fault     <= 1'b0;
          m1_read_data <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rvsteel_bus_arbiter.sv
// Scoreboard bench for rvsteel_bus_arbiter: manager drivers, a memory model and a response monitor.
module tb_rvsteel_bus_arbiter;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
  } req_t;

  typedef struct {
    logic        owner;
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
  } sexp_t;

  typedef struct {
    logic        owner;
    logic [31:0] data;
    logic        fault;
  } rexp_t;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] m0_address = '0, m1_address = '0;
  logic        m0_read_request = 1'b0, m0_write_request = 1'b0;
  logic        m1_read_request = 1'b0, m1_write_request = 1'b0;
  logic [31:0] m0_write_data = '0, m1_write_data = '0;
  logic [3:0]  m0_write_strobe = '0, m1_write_strobe = '0;
  logic [31:0] m0_read_data, m1_read_data;
  logic        m0_response, m1_response, m0_fault, m1_fault;
  logic [31:0] s_address, s_write_data;
  logic        s_read_request, s_write_request;
  logic [3:0]  s_write_strobe;
  logic [31:0] s_read_data = '0;
  logic        s_response = 1'b0;
  logic        grant_owner, busy;

  rvsteel_bus_arbiter #(
    .ADDR_WIDTH(32),
    .DATA_WIDTH(32),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clock(clock), .reset(reset),
    .m0_address(m0_address), .m0_read_request(m0_read_request),
    .m0_write_request(m0_write_request), .m0_write_data(m0_write_data),
    .m0_write_strobe(m0_write_strobe), .m0_read_data(m0_read_data),
    .m0_response(m0_response), .m0_fault(m0_fault),
    .m1_address(m1_address), .m1_read_request(m1_read_request),
    .m1_write_request(m1_write_request), .m1_write_data(m1_write_data),
    .m1_write_strobe(m1_write_strobe), .m1_read_data(m1_read_data),
    .m1_response(m1_response), .m1_fault(m1_fault),
    .s_address(s_address), .s_read_request(s_read_request),
    .s_write_request(s_write_request), .s_write_data(s_write_data),
    .s_write_strobe(s_write_strobe), .s_read_data(s_read_data),
    .s_response(s_response), .grant_owner(grant_owner), .busy(busy)
  );

  always #5 clock = ~clock;

  int passed = 0;
  int total  = 0;
  int cyc    = 0;
  int issue0_cyc = 0, sreq_cyc = 0, sresp_cyc = 0, resp_cyc = 0;
  logic mem_on = 1'b1;
  logic seen   = 1'b0;

  req_t  mq0[$];
  req_t  mq1[$];
  sexp_t exp_s[$];
  rexp_t exp_r[$];
  logic [31:0] mem [logic [31:0]];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : 32'h0;
  endfunction

  task automatic req(input int m, input logic rd, input logic wr, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic [3:0] strb);
    req_t r;
    r = '{rd: rd, wr: wr, addr: addr, wdata: wdata, strb: strb};
    if (m == 0) mq0.push_back(r);
    else        mq1.push_back(r);
  endtask

  task automatic exp_sub(input logic owner, input logic rd, input logic wr, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] strb);
    exp_s.push_back('{owner: owner, rd: rd, wr: wr, addr: addr, wdata: wdata, strb: strb});
  endtask

  task automatic exp_resp(input logic owner, input logic [31:0] data, input logic fault);
    exp_r.push_back('{owner: owner, data: data, fault: fault});
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_r.size() > 0 || exp_s.size() > 0 || mq0.size() > 0 || mq1.size() > 0) && n < 100) begin
      @(posedge clock);
      n++;
    end
    check("transactions outstanding after budget", exp_r.size() + exp_s.size(), 0);
    #2;
  endtask

  initial forever begin
    @(posedge clock);
    cyc++;
  end

  // Manager drivers: hold the head request until its response, then present the next one.
  initial forever begin
    @(negedge clock);
    if (m0_response && mq0.size() > 0) mq0.delete(0);
    if (m1_response && mq1.size() > 0) mq1.delete(0);
    if (mq0.size() > 0) begin
      if (!(m0_read_request || m0_write_request)) issue0_cyc = cyc;
      m0_read_request  = mq0[0].rd;
      m0_write_request = mq0[0].wr;
      m0_address       = mq0[0].addr;
      m0_write_data    = mq0[0].wdata;
      m0_write_strobe  = mq0[0].strb;
    end else begin
      m0_read_request  = 1'b0;
      m0_write_request = 1'b0;
    end
    if (mq1.size() > 0) begin
      m1_read_request  = mq1[0].rd;
      m1_write_request = mq1[0].wr;
      m1_address       = mq1[0].addr;
      m1_write_data    = mq1[0].wdata;
      m1_write_strobe  = mq1[0].strb;
    end else begin
      m1_read_request  = 1'b0;
      m1_write_request = 1'b0;
    end
  end

  // Memory: answers one cycle after it first sees a request; writes honour byte strobes.
  initial forever begin
    @(negedge clock);
    if (!mem_on) begin
      seen = 1'b0;
    end else if (s_response) begin
      s_response  = 1'b0;
      s_read_data = '0;
    end else if (s_read_request || s_write_request) begin
      if (!seen) begin
        sexp_t e;
        seen     = 1'b1;
        sreq_cyc = cyc;
        if (exp_s.size() == 0) begin
          check("unexpected subordinate request", {s_read_request, s_write_request}, 0);
        end else begin
          e = exp_s.pop_front();
          check("grant_owner", grant_owner, e.owner);
          check("s_read_request", s_read_request, e.rd);
          check("s_write_request", s_write_request, e.wr);
          check("s_address", s_address, e.addr);
          if (e.wr) begin
            check("s_write_data", s_write_data, e.wdata);
            check("s_write_strobe", s_write_strobe, e.strb);
          end
        end
        if (s_write_request) begin
          logic [31:0] cur;
          cur = mem_rd(s_address);
          for (int i = 0; i < 4; i++)
            if (s_write_strobe[i]) cur[8*i +: 8] = s_write_data[8*i +: 8];
          mem[s_address] = cur;
        end
      end else begin
        s_response  = 1'b1;
        s_read_data = s_read_request ? mem_rd(s_address) : 32'hDEADDEAD;
        sresp_cyc   = cyc;
        seen        = 1'b0;
      end
    end else begin
      seen = 1'b0;
    end
  end

  // Response monitor.
  initial forever begin
    @(negedge clock);
    if (m0_response || m1_response) begin
      rexp_t e;
      logic  owner;
      resp_cyc = cyc;
      owner    = m1_response;
      check("single response pulse", m0_response & m1_response, 0);
      if (exp_r.size() == 0) begin
        check("unexpected manager response", {m1_response, m0_response}, 0);
      end else begin
        e = exp_r.pop_front();
        check("response owner", owner, e.owner);
        check("read_data", owner ? m1_read_data : m0_read_data, e.data);
        check("fault", owner ? m1_fault : m0_fault, e.fault);
        check("other manager read_data", owner ? m0_read_data : m1_read_data, 0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    mem[32'h100] = 32'hCAFEF00D;
    mem[32'h200] = 32'h0BADBEEF;

    repeat (3) @(posedge clock);
    #2;
    check("reset busy", busy, 0);
    check("reset grant_owner", grant_owner, 0);
    check("reset s_read_request", s_read_request, 0);
    check("reset s_address", s_address, 0);
    check("reset m0_response", m0_response, 0);
    check("reset m1_read_data", m1_read_data, 0);
    reset = 1'b0;

    // Contention straight after reset: m0 wins the first tie.
    req(0, 1, 0, 32'h100, 0, 0);
    req(1, 1, 0, 32'h200, 0, 0);
    exp_sub(0, 1, 0, 32'h100, 0, 0);
    exp_sub(1, 1, 0, 32'h200, 0, 0);
    exp_resp(0, 32'hCAFEF00D, 0);
    exp_resp(1, 32'h0BADBEEF, 0);
    drain();

    // Single read latency.
    req(0, 1, 0, 32'h100, 0, 0);
    exp_sub(0, 1, 0, 32'h100, 0, 0);
    exp_resp(0, 32'hCAFEF00D, 0);
    drain();
    check("request to s_read_request cycles", sreq_cyc - issue0_cyc, 1);
    check("s_response to m0_response cycles", resp_cyc - sresp_cyc, 1);

    // Write pass-through from m1; read data must be 0 even though memory drives data.
    req(1, 0, 1, 32'h40, 32'h12345678, 4'b0011);
    exp_sub(1, 0, 1, 32'h40, 32'h12345678, 4'b0011);
    exp_resp(1, 32'h0, 0);
    drain();

    // Fairness: both hold requests for four transactions, last winner was m1.
    req(0, 1, 0, 32'h100, 0, 0);
    req(0, 1, 0, 32'h40, 0, 0);
    req(1, 1, 0, 32'h200, 0, 0);
    req(1, 0, 1, 32'h80, 32'hA5A5A5A5, 4'b1111);
    exp_sub(0, 1, 0, 32'h100, 0, 0);
    exp_sub(1, 1, 0, 32'h200, 0, 0);
    exp_sub(0, 1, 0, 32'h40, 0, 0);
    exp_sub(1, 0, 1, 32'h80, 32'hA5A5A5A5, 4'b1111);
    exp_resp(0, 32'hCAFEF00D, 0);
    exp_resp(1, 32'h0BADBEEF, 0);
    exp_resp(0, 32'h00005678, 0);
    exp_resp(1, 32'h0, 0);
    drain();

    // Read and write together: only the read is forwarded.
    req(0, 1, 1, 32'h100, 32'hFFFFFFFF, 4'b1111);
    exp_sub(0, 1, 0, 32'h100, 0, 0);
    exp_resp(0, 32'hCAFEF00D, 0);
    drain();

    // Reset while GRANT is holding a read; a late s_response must be ignored.
    mem_on = 1'b0;
    req(0, 1, 0, 32'h300, 0, 0);
    n = 0;
    while (!s_read_request && n < 20) begin
      @(negedge clock);
      n++;
    end
    check("s_read_request before reset", s_read_request, 1);
    @(posedge clock);
    #2;
    reset = 1'b1;
    mq0.delete();
    @(posedge clock);
    #2;
    check("reset in GRANT s_read_request", s_read_request, 0);
    check("reset in GRANT busy", busy, 0);
    check("reset in GRANT s_address", s_address, 0);
    check("reset in GRANT m0_response", m0_response, 0);
    reset       = 1'b0;
    s_response  = 1'b1;
    s_read_data = 32'h11111111;
    repeat (2) @(posedge clock);
    #2;
    check("late s_response busy", busy, 0);
    check("late s_response m0_response", m0_response, 0);
    check("late s_response m0_read_data", m0_read_data, 0);
    s_response  = 1'b0;
    s_read_data = '0;
    mem_on      = 1'b1;

`ifdef RVSTEEL_BUS_TIMEOUT_EN
    // Silent subordinate: request held for eight GRANT cycles, then a faulted response.
    mem_on = 1'b0;
    req(1, 1, 0, 32'h500, 0, 0);
    exp_resp(1, 32'h0, 1);
    n = 0;
    for (int i = 0; i < 40 && !m1_response; i++) begin
      @(negedge clock);
      if (s_read_request) n++;
    end
    check("timeout GRANT cycles", n, 8);
    drain();
    mem_on = 1'b1;
`endif

    repeat (3) @(posedge clock);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
